deck_controller: RTL and testbench

Sequencer that owns the single-port card RAM and maintains a 52-card deck in it as a singly linked list. Builds a fresh ordered deck on command, deals cards from the head, and accepts returned cards onto the tail. Sits between game logic (dealer/player FSMs) and the card RAM; no other block writes the RAM while this block is in use.

---
 rtl/deck_pkg.sv | 40 ++++
 rtl/deck_controller_card_home_addr.sv | 22 ++
 rtl/deck_controller.sv | 279 +++++++++++++++++++++++++++
 tb/tb_deck_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/deck_pkg.sv
// Shared constants, state encoding and card/word helpers for the deck controller.
package deck_pkg;

   localparam logic [9:0] NULL_PTR        = 10'h3FF;
   localparam int         DECK_SIZE       = 52;
   localparam int         VALUES_PER_SUIT = 13;

   // Field offsets inside a 16-bit RAM word {next[9:0], suit[1:0], value[3:0]}
   localparam int VALUE_LSB = 0;
   localparam int SUIT_LSB  = 4;
   localparam int NEXT_LSB  = 6;

   typedef enum logic [2:0] {
      ST_EMPTY       = 3'd0,
      ST_BUILD       = 3'd1,
      ST_READY       = 3'd2,
      ST_DEAL_RD     = 3'd3,
      ST_DEAL_CAP    = 3'd4,
      ST_DEAL_OUT    = 3'd5,
      ST_RET_WR_NEW  = 3'd6,
      ST_RET_WR_TAIL = 3'd7
   } state_t;

   // Card index = suit*13 + (value-1); only meaningful for value 1..13.
   function automatic logic [5:0] card_index(input logic [1:0] suit, input logic [3:0] value);
      return ({4'd0, suit} * 6'(VALUES_PER_SUIT)) + {2'd0, value} - 6'd1;
   endfunction

   // Pack a linked-list node word.
   function automatic logic [15:0] make_word(input logic [9:0] next, input logic [1:0] suit,
                                             input logic [3:0] value);
      logic [15:0] w;
      w                   = 16'd0;
      w[NEXT_LSB  +: 10]  = next;
      w[SUIT_LSB  +: 2]   = suit;
      w[VALUE_LSB +: 4]   = value;
      return w;
   endfunction

endpackage

// File: rtl/deck_controller_card_home_addr.sv
// Maps a card {suit, value} to its deck index and fixed home address in RAM.
module card_home_addr
   import deck_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic [1:0]        suit,
   input  logic [3:0]        value,
   output logic [5:0]        index,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);

   // Pure combinational mapping; index/addr are don't-care when in_range is low.
   always_comb begin
      in_range = (value >= 4'd1) && (value <= 4'd13);
      index    = card_index(suit, value);
      addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(index);
   end

endmodule

// File: rtl/deck_controller.sv
// Owns the card RAM and keeps a 52-card deck in it as a singly linked list:
// builds an ordered deck, deals from the head and appends returns at the tail.
module deck_controller
   import deck_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic              deal_req,
   input  logic              ret_req,
   input  logic [5:0]        ret_card,
   output logic [7:0]        card_out,
   output logic              deal_valid,
   output logic              deal_empty,
   output logic              ret_err,
   output logic              busy,
   output logic [5:0]        count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   output logic              mem_wren,
   input  logic [15:0]       mem_q
);

   localparam logic [ADDR_W-1:0] NULL_ADDR  = ADDR_W'(NULL_PTR);
   localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
   localparam logic [5:0]        FULL_COUNT = 6'(DECK_SIZE);
   localparam logic [5:0]        LAST_INDEX = 6'(DECK_SIZE - 1);

   state_t                state_r, state_s;
   logic [ADDR_W-1:0]     head_r, head_s, tail_r, tail_s;
   logic [1:0]            tsuit_r, tsuit_s;
   logic [3:0]            tval_r, tval_s;
   logic [5:0]            count_r, count_s;
   logic [DECK_SIZE-1:0]  present_r, present_s;
   logic [1:0]            b_suit_r, b_suit_s;
   logic [3:0]            b_value_r, b_value_s;
   logic [5:0]            b_idx_r, b_idx_s;
   logic [5:0]            rcard_r, rcard_s, ridx_r, ridx_s;
   logic [ADDR_W-1:0]     rhome_r, rhome_s;
   logic [15:0]           cap_r, cap_s;
   logic [7:0]            card_r, card_s;
   logic                  dv_r, dv_s, de_r, de_s, re_r, re_s, busy_r, busy_s;
   logic [ADDR_W-1:0]     addr_r, addr_s;
   logic [15:0]           data_r, data_s;
   logic                  wren_r, wren_s;

   logic [1:0]            ch_suit_s;
   logic [3:0]            ch_value_s;
   logic [5:0]            ch_index_s;
   logic [ADDR_W-1:0]     ch_addr_s;
   logic                  ch_in_range_s;
   logic                  ret_ok_s;

   // The home-address mapper serves the build walk while building, the return port otherwise.
   always_comb begin
      if (state_r == ST_BUILD) begin
         ch_suit_s  = b_suit_r;
         ch_value_s = b_value_r;
      end else begin
         ch_suit_s  = ret_card[5:4];
         ch_value_s = ret_card[3:0];
      end
   end

   card_home_addr #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_home (
      .suit     (ch_suit_s),
      .value    (ch_value_s),
      .index    (ch_index_s),
      .addr     (ch_addr_s),
      .in_range (ch_in_range_s)
   );

   // A return is accepted only for a legal value whose card is not already in the deck.
   always_comb begin
      ret_ok_s = ch_in_range_s && !present_r[ch_index_s];
   end

   // Next-state and next-output logic; every register holds unless a branch updates it.
   always_comb begin
      state_s   = state_r;
      head_s    = head_r;
      tail_s    = tail_r;
      tsuit_s   = tsuit_r;
      tval_s    = tval_r;
      count_s   = count_r;
      present_s = present_r;
      b_suit_s  = b_suit_r;
      b_value_s = b_value_r;
      b_idx_s   = b_idx_r;
      rcard_s   = rcard_r;
      ridx_s    = ridx_r;
      rhome_s   = rhome_r;
      cap_s     = cap_r;
      card_s    = card_r;
      dv_s      = 1'b0;
      de_s      = 1'b0;
      re_s      = 1'b0;
      addr_s    = addr_r;
      data_s    = data_r;
      wren_s    = 1'b0;

      if (start) begin
         // Card 0 is loaded into the write registers right away so the walk takes 52 cycles.
         state_s   = ST_BUILD;
         addr_s    = BASE;
         data_s    = make_word(10'(BASE + ADDR_W'(1)), 2'd0, 4'd1);
         wren_s    = 1'b1;
         b_suit_s  = 2'd0;
         b_value_s = 4'd2;
         b_idx_s   = 6'd1;
      end else begin
         case (state_r)
            ST_EMPTY, ST_READY: begin
               if (ret_req) begin
                  if (ret_ok_s) begin
                     rcard_s = ret_card;
                     ridx_s  = ch_index_s;
                     rhome_s = ch_addr_s;
                     addr_s  = ch_addr_s;
                     data_s  = make_word(NULL_PTR, ret_card[5:4], ret_card[3:0]);
                     wren_s  = 1'b1;
                     state_s = ST_RET_WR_NEW;
                  end else begin
                     re_s = 1'b1;
                  end
               end else if (deal_req) begin
                  if (count_r == 6'd0) begin
                     de_s = 1'b1;
                  end else begin
                     addr_s  = head_r;
                     state_s = ST_DEAL_RD;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            ST_BUILD: begin
               if (b_idx_r == FULL_COUNT) begin
                  head_s    = BASE;
                  tail_s    = BASE + ADDR_W'(DECK_SIZE - 1);
                  tsuit_s   = 2'd3;
                  tval_s    = 4'd13;
                  count_s   = FULL_COUNT;
                  present_s = {DECK_SIZE{1'b1}};
                  state_s   = ST_READY;
               end else begin
                  addr_s  = ch_addr_s;
                  data_s  = make_word((b_idx_r == LAST_INDEX) ? NULL_PTR : 10'(ch_addr_s + ADDR_W'(1)),
                                      b_suit_r, b_value_r);
                  wren_s  = 1'b1;
                  b_idx_s = b_idx_r + 6'd1;
                  if (b_value_r == 4'(VALUES_PER_SUIT)) begin
                     b_value_s = 4'd1;
                     b_suit_s  = b_suit_r + 2'd1;
                  end else begin
                     b_value_s = b_value_r + 4'd1;
                  end
               end
            end
            ST_DEAL_RD: begin
               state_s = ST_DEAL_CAP;
            end
            ST_DEAL_CAP: begin
               cap_s   = mem_q;
               card_s  = {2'b00, mem_q[SUIT_LSB +: 2], mem_q[VALUE_LSB +: 4]};
               dv_s    = 1'b1;
               state_s = ST_DEAL_OUT;
            end
            ST_DEAL_OUT: begin
               present_s[card_index(cap_r[SUIT_LSB +: 2], cap_r[VALUE_LSB +: 4])] = 1'b0;
               count_s = count_r - 6'd1;
               if (count_r == 6'd1) begin
                  head_s  = NULL_ADDR;
                  tail_s  = NULL_ADDR;
                  state_s = ST_EMPTY;
               end else begin
                  head_s  = ADDR_W'(cap_r[NEXT_LSB +: 10]);
                  state_s = ST_READY;
               end
            end
            ST_RET_WR_NEW: begin
               if (count_r == 6'd0) begin
                  head_s           = rhome_r;
                  tail_s           = rhome_r;
                  tsuit_s          = rcard_r[5:4];
                  tval_s           = rcard_r[3:0];
                  count_s          = 6'd1;
                  present_s[ridx_r] = 1'b1;
                  state_s          = ST_READY;
               end else begin
                  // Old tail now points at the returned card.
                  addr_s  = tail_r;
                  data_s  = make_word(10'(rhome_r), tsuit_r, tval_r);
                  wren_s  = 1'b1;
                  state_s = ST_RET_WR_TAIL;
               end
            end
            ST_RET_WR_TAIL: begin
               tail_s            = rhome_r;
               tsuit_s           = rcard_r[5:4];
               tval_s            = rcard_r[3:0];
               count_s           = count_r + 6'd1;
               present_s[ridx_r] = 1'b1;
               state_s           = ST_READY;
            end
            default: begin
               state_s = ST_EMPTY;
            end
         endcase
      end

      busy_s = (state_s != ST_EMPTY) && (state_s != ST_READY);
   end

   // State and datapath registers; all outputs come straight from these.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r   <= ST_EMPTY;
         head_r    <= NULL_ADDR;
         tail_r    <= NULL_ADDR;
         tsuit_r   <= 2'd0;
         tval_r    <= 4'd0;
         count_r   <= 6'd0;
         present_r <= {DECK_SIZE{1'b0}};
         b_suit_r  <= 2'd0;
         b_value_r <= 4'd0;
         b_idx_r   <= 6'd0;
         rcard_r   <= 6'd0;
         ridx_r    <= 6'd0;
         rhome_r   <= {ADDR_W{1'b0}};
         cap_r     <= 16'd0;
         card_r    <= 8'd0;
         dv_r      <= 1'b0;
         de_r      <= 1'b0;
         re_r      <= 1'b0;
         busy_r    <= 1'b0;
         addr_r    <= {ADDR_W{1'b0}};
         data_r    <= 16'd0;
         wren_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         head_r    <= head_s;
         tail_r    <= tail_s;
         tsuit_r   <= tsuit_s;
         tval_r    <= tval_s;
         count_r   <= count_s;
         present_r <= present_s;
         b_suit_r  <= b_suit_s;
         b_value_r <= b_value_s;
         b_idx_r   <= b_idx_s;
         rcard_r   <= rcard_s;
         ridx_r    <= ridx_s;
         rhome_r   <= rhome_s;
         cap_r     <= cap_s;
         card_r    <= card_s;
         dv_r      <= dv_s;
         de_r      <= de_s;
         re_r      <= re_s;
         busy_r    <= busy_s;
         addr_r    <= addr_s;
         data_r    <= data_s;
         wren_r    <= wren_s;
      end
   end

   assign card_out   = card_r;
   assign deal_valid = dv_r;
   assign deal_empty = de_r;
   assign ret_err    = re_r;
   assign busy       = busy_r;
   assign count      = count_r;
   assign mem_addr   = addr_r;
   assign mem_data   = data_r;
   assign mem_wren   = wren_r;

endmodule

// File: tb/tb_deck_controller.sv
// Self-checking bench for deck_controller: directed steps plus a random deal/return mix,
// checked against a queue model of the deck built from the card-game rules.
module tb_deck_controller;

   logic        clock, resetn, start, deal_req, ret_req;
   logic [5:0]  ret_card;
   logic [7:0]  card_out;
   logic        deal_valid, deal_empty, ret_err, busy, mem_wren;
   logic [5:0]  count;
   logic [9:0]  mem_addr;
   logic [15:0] mem_data, mem_q;

   logic [15:0] ram [0:1023];
   int          wr_count = 0;
   int          n_pass   = 0;
   int          n_total  = 0;
   int          n_fail   = 0;
   logic [5:0]  model [$];

   deck_controller #(.ADDR_W(10), .BASE_ADDR(0)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .deal_req   (deal_req),
      .ret_req    (ret_req),
      .ret_card   (ret_card),
      .card_out   (card_out),
      .deal_valid (deal_valid),
      .deal_empty (deal_empty),
      .ret_err    (ret_err),
      .busy       (busy),
      .count      (count),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_wren   (mem_wren),
      .mem_q      (mem_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port synchronous RAM: read data appears the cycle after the address is clocked in.
   always @(posedge clock) begin
      if (mem_wren) begin
         ram[mem_addr] <= mem_data;
         wr_count      <= wr_count + 1;
      end
      mem_q <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_deck(input logic [5:0] c);
      foreach (model[i]) if (model[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all_zero(input string tag);
      check(tag, 64'({card_out, deal_valid, deal_empty, ret_err, busy, count,
                      mem_addr, mem_data, mem_wren}), 64'd0);
   endtask

   task automatic do_deal(input string tag);
      logic [3:0] dv_h, de_h, busy_h;
      logic [7:0] card_seen;
      logic [5:0] exp_card;
      bit         have;
      int         w0;
      have     = (model.size() != 0);
      exp_card = 6'd0;
      if (have) exp_card = model.pop_front();
      card_seen = 8'hFF;
      w0 = wr_count;
      @(negedge clock); deal_req = 1'b1;
      @(posedge clock); #1 deal_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         dv_h[3-k]   = deal_valid;
         de_h[3-k]   = deal_empty;
         busy_h[3-k] = busy;
         if (k == 2) card_seen = card_out;
      end
      if (have) begin
         check({tag, ".valid_timing"}, 64'(dv_h), 64'(4'b0010));
         check({tag, ".busy_timing"}, 64'(busy_h), 64'(4'b1110));
         check({tag, ".card"}, 64'(card_seen), 64'({2'b00, exp_card}));
      end else begin
         check({tag, ".empty_strobe"}, 64'(de_h), 64'(4'b1000));
         check({tag, ".no_valid"}, 64'({dv_h, busy_h}), 64'(8'h00));
      end
      check({tag, ".no_writes"}, 64'(wr_count - w0), 64'd0);
      check({tag, ".count"}, 64'(count), 64'(model.size()));
   endtask

   task automatic do_ret(input logic [5:0] card, input string tag);
      logic [3:0] re_h, busy_h;
      bit         ok;
      int         was, w0;
      ok  = (card[3:0] >= 4'd1) && (card[3:0] <= 4'd13) && !in_deck(card);
      was = model.size();
      w0  = wr_count;
      @(negedge clock); ret_req = 1'b1; ret_card = card;
      @(posedge clock); #1 ret_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         re_h[3-k]   = ret_err;
         busy_h[3-k] = busy;
      end
      if (ok) begin
         model.push_back(card);
         check({tag, ".no_err"}, 64'(re_h), 64'd0);
         check({tag, ".busy_timing"}, 64'(busy_h), (was == 0) ? 64'(4'b1000) : 64'(4'b1100));
         check({tag, ".writes"}, 64'(wr_count - w0), (was == 0) ? 64'd1 : 64'd2);
      end else begin
         check({tag, ".err_strobe"}, 64'(re_h), 64'(4'b1000));
         check({tag, ".not_busy"}, 64'(busy_h), 64'd0);
         check({tag, ".no_writes"}, 64'(wr_count - w0), 64'd0);
      end
      check({tag, ".count"}, 64'(count), 64'(model.size()));
   endtask

   // Build a fresh deck; optionally raise a return request in the same cycle as start.
   task automatic do_build(input string tag, input bit with_ret, input logic [5:0] rc);
      int cyc, w0;
      bit re_seen;
      w0 = wr_count;
      re_seen = 1'b0;
      @(negedge clock); start = 1'b1;
      if (with_ret) begin ret_req = 1'b1; ret_card = rc; end
      @(posedge clock); #1 start = 1'b0; ret_req = 1'b0;
      cyc = 0;
      @(negedge clock);
      while (busy === 1'b1 && cyc < 200) begin
         re_seen = re_seen | ret_err;
         cyc++;
         @(negedge clock);
      end
      check({tag, ".busy_cycles"}, 64'(cyc), 64'd52);
      check({tag, ".writes"}, 64'(wr_count - w0), 64'd52);
      check({tag, ".count"}, 64'(count), 64'd52);
      check({tag, ".no_ret_err"}, 64'(re_seen), 64'd0);
      model.delete();
      for (int s = 0; s < 4; s++)
         for (int v = 1; v <= 13; v++)
            model.push_back({2'(s), 4'(v)});
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; deal_req = 1'b0; ret_req = 1'b0; ret_card = 6'd0;
      repeat (3) @(negedge clock);
      check_all_zero("reset_hold");
      resetn = 1'b1;
      @(negedge clock);
      check_all_zero("after_reset");
      do_deal("deal_from_reset");

      // Full ordered deal, then a refused deal
      do_build("build1", 1'b0, 6'd0);
      while (model.size() > 0) do_deal("ordered");
      do_deal("drained");

      // Return onto the tail of a partly dealt deck
      do_build("build2", 1'b0, 6'd0);
      do_deal("d2a");
      do_deal("d2b");
      do_ret(6'h01, "ret_0_1");
      while (model.size() > 0) do_deal("tail_walk");

      // Refused returns on a full deck
      do_build("build3", 1'b0, 6'd0);
      do_ret(6'h25, "ret_dup_2_5");
      do_ret(6'h10, "ret_val0");
      do_ret(6'h3E, "ret_val14");

      // Random mix of deals and returns
      repeat ($urandom_range(10, 30)) do_deal("rnd_pre");
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 1) == 1) do_deal("rnd_deal");
         else do_ret(6'($urandom_range(0, 63)), "rnd_ret");
      end

      // Return into an empty deck
      while (model.size() > 0) do_deal("drain");
      do_ret(6'h17, "ret_empty_1_7");
      do_deal("deal_1_7");
      do_deal("empty_again");
      do_ret(6'h03, "ret_empty_0_3");
      do_ret(6'h2B, "ret_second");
      do_deal("deal_0_3");
      do_deal("deal_2_11");

      // start beats a simultaneous return
      do_build("build4", 1'b0, 6'd0);
      do_deal("d4");
      do_build("build_vs_ret", 1'b1, 6'h01);
      do_deal("first_after_rebuild");

      // Reset in the middle of a build
      @(negedge clock); start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (20) @(negedge clock);
      #2 resetn = 1'b0;
      #1 check_all_zero("reset_mid_build");
      model.delete();
      @(negedge clock); resetn = 1'b1;
      @(negedge clock);
      check_all_zero("after_mid_reset");
      do_deal("deal_after_abort");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
